mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Memory-mapped I/O bridge that sits between the single-cycle MIPS core's data port and the data memory. It consumes the core's `memwrite`/`dataadr`/`writedata` bus, steers accesses either to DMEM or to a small bank of board I/O registers, and returns the selected read data to the core. The I/O bank drives 16 LEDs and an 8-digit multiplexed seven-segment display. It also samples 16 switches and one push-button.

## Interface
Parameters:
- `SCAN_BITS`, 18: width of the display scan counter; the top 3 bits select the digit.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  store strobe from the core.
- `dataadr`  in  32  byte address from the core.
- `writedata`  in  32  store data from the core.
- `dmem_readdata`  in  32  read data from DMEM.
- `dmem_we`  out  1  write enable to DMEM.
- `readdata`  out  32  load data returned to the core.
- `switches`  in  16  raw switch pins (asynchronous).
- `btn`  in  1  raw push-button pin (asynchronous, active-high).
- `led`  out  16  LED outputs.
- `an`  out  8  digit enables, active-low, one-hot.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.

## Operation
- Decode: `io_sel = dataadr[7]`.
  - Addresses 0x80–0xFF (mod 256) are I/O; all others go to DMEM.
  - `dmem_we = memwrite & ~io_sel`.
- I/O registers, word-aligned, decoded on `dataadr[3:2]` when `dataadr[6:4] == 0`:
  - 0x80 LED: R/W. A write stores `writedata[15:0]`. A read returns {16'b0, led}.
  - 0x84 SEGDATA: R/W, 32 bits. Displayed as 8 hex digits; digit i shows bits [4i+3:4i].
  - 0x88 SWITCH: read-only. Returns {16'b0, sw_sync}. Writes are ignored.
  - 0x8C STATUS: bit0 = sticky button flag; reads return {31'b0, flag}. A write of any value clears the flag.
  - Other I/O addresses (0x90–0xFF): writes ignored, reads return 0.
- `readdata` is combinational: `io_sel ? io_mux : dmem_readdata`.
- Synchronisers:
  - `switches` and `btn` each pass through a 2-flop synchroniser.
  - A button rising edge is detected between synchronised stages 2 and 3 (a third flop).
- Sticky flag: set on a detected edge. If an edge and a STATUS write occur in the same cycle, **set wins**.
- Scanner:
  - Free-running `SCAN_BITS` counter that wraps to 0.
  - `digit = cnt[SCAN_BITS-1 -: 3]`.
  - `an` = ~(1 << digit).
  - `seg` = active-low hex decode of the selected nibble (0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110).

## Timing
- Reset values (asserted asynchronously, held while `reset`=0):
  - led=0, SEGDATA=0, flag=0, sync flops=0, cnt=0.
  - Hence an=8'b11111110, seg=7'b1000000.
- Register writes take effect on the `clk` edge where `memwrite & io_sel` and the address match. The new value is visible on outputs and readback from the next cycle.
- Reads have zero latency (same cycle as the address), as the single-cycle core requires.
- Switch latency: a pin change appears in SWITCH readback 2 cycles later.
- Button latency: a button press sets the flag 3 edges after the pin rises.
- Digit dwell time is 2^(SCAN_BITS-3) cycles; the sequence is digit 0→7, then wraps to 0.
- Reset mid-scan returns the scanner to digit 0 immediately. A reset in the same cycle as a write drops the write.

## Configuration
- `MMIO_BLANK_LEADING_ZERO_EN`:
  - Defined: a digit i>0 is blanked (seg=7'b1111111, `an` unchanged) when SEGDATA[31:4i] == 0. Digit 0 is never blanked.
  - Undefined: all 8 digits always show their hex value.

## Test plan
- Reset, then release → led=0, an=8'hFE, seg=7'h40, flag=0. DMEM read 0x12345678 at address 0x10 passes through to `readdata`.
- Store 0xABCD1234 to 0x80 → dmem_we=0; led=16'h1234 next cycle. A load from 0x80 returns 0x00001234.
- Store 0x00000000 to 0x54 → dmem_we=1 and LED unchanged. Store to 0xA0 → ignored; load from 0xA0 returns 0.
- switches=16'h5A5A → load from 0x88 returns 0x00005A5A starting 2 cycles later, 0 before that.
- btn pulse → load from 0x8C returns 1 after 3 cycles. Write to 0x8C → 0. An edge coincident with the write → the flag remains 1.
- With SCAN_BITS=4 and SEGDATA=0x00000F08: digit 0 seg=7'h00, digit 2 seg=7'h0E. Digit 3 shows seg=7'h40 without the macro and 7'h7F with it. `an` cycles 0xFE→0x7F and wraps.

Source files
------------

// File: rtl/mmio_bridge.sv
// MMIO bridge: steers core loads/stores to DMEM or to LED/7-seg/switch/button registers.
// Latency: reads are combinational; register writes are visible the cycle after the store edge.
// Backpressure: none, every access completes in one cycle. Optional MMIO_BLANK_LEADING_ZERO_EN blanks leading-zero digits.
module mmio_bridge #(
    parameter int SCAN_BITS = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic [31:0] dmem_readdata,
    output logic        dmem_we,
    output logic [31:0] readdata,
    input  logic [15:0] switches,
    input  logic        btn,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    logic                 io_sel;
    logic                 reg_hit;
    logic                 wr_led;
    logic                 wr_seg;
    logic                 wr_status;
    logic [31:0]          segdata;
    logic                 flag;
    logic [15:0]          sw_s1;
    logic [15:0]          sw_s2;
    logic                 btn_s1;
    logic                 btn_s2;
    logic                 btn_s3;
    logic                 btn_rise;
    logic [SCAN_BITS-1:0] cnt;
    logic [2:0]           digit;
    logic [31:0]          shifted;
    logic [3:0]           nibble;
    logic                 blank;
    logic [6:0]           hex_seg;
    logic [31:0]          io_mux;
    logic                 unused_adr;

    assign unused_adr = ^{dataadr[31:8], dataadr[1:0]};

    assign io_sel    = dataadr[7];
    assign reg_hit   = io_sel & (dataadr[6:4] == 3'd0);
    assign dmem_we   = memwrite & ~io_sel;
    assign wr_led    = memwrite & reg_hit & (dataadr[3:2] == 2'd0);
    assign wr_seg    = memwrite & reg_hit & (dataadr[3:2] == 2'd1);
    assign wr_status = memwrite & reg_hit & (dataadr[3:2] == 2'd3);
    assign btn_rise  = btn_s2 & ~btn_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led     <= 16'd0;
            segdata <= 32'd0;
            flag    <= 1'b0;
            sw_s1   <= 16'd0;
            sw_s2   <= 16'd0;
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            btn_s3  <= 1'b0;
            cnt     <= '0;
        end else begin
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
            btn_s1 <= btn;
            btn_s2 <= btn_s1;
            btn_s3 <= btn_s2;
            cnt    <= cnt + SCAN_BITS'(1);
            if (wr_led)
                led <= writedata[15:0];
            if (wr_seg)
                segdata <= writedata;
            // A new press outranks a clear landing in the same cycle.
            if (btn_rise)
                flag <= 1'b1;
            else if (wr_status)
                flag <= 1'b0;
        end
    end

    always_comb begin
        io_mux = 32'd0;
        if (reg_hit) begin
            case (dataadr[3:2])
                2'd0:    io_mux = {16'd0, led};
                2'd1:    io_mux = segdata;
                2'd2:    io_mux = {16'd0, sw_s2};
                default: io_mux = {31'd0, flag};
            endcase
        end
    end

    assign readdata = io_sel ? io_mux : dmem_readdata;

    assign digit   = cnt[SCAN_BITS-1 -: 3];
    assign an      = ~(8'b1 << digit);
    assign shifted = segdata >> {digit, 2'b00};
    assign nibble  = shifted[3:0];

`ifdef MMIO_BLANK_LEADING_ZERO_EN
    assign blank = (digit != 3'd0) && (shifted == 32'd0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        hex_seg = 7'b1111111;
        case (nibble)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    end

    assign seg = blank ? 7'b1111111 : hex_seg;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a 4-bit scan counter (2-cycle digit dwell).
module tb_mmio_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] dmem_readdata;
    logic        dmem_we;
    logic [31:0] readdata;
    logic [15:0] switches;
    logic        btn;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    mmio_bridge #(.SCAN_BITS(4)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .dmem_readdata(dmem_readdata), .dmem_we(dmem_we),
        .readdata(readdata), .switches(switches), .btn(btn), .led(led),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; memwrite = 1'b0; dataadr = 32'h10; writedata = 32'd0;
        dmem_readdata = 32'h12345678; switches = 16'd0; btn = 1'b0;
        step(); step();
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led: got %h expected 0000", led); end
        n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL reset_an: got %h expected fe", an); end
        n_checks++; if (seg !== 7'h40) begin n_fail++; $display("FAIL reset_seg: got %h expected 40", seg); end
        n_checks++; if (readdata !== 32'h12345678) begin n_fail++; $display("FAIL dmem_passthru: got %h expected 12345678", readdata); end
        dataadr = 32'h8C; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL reset_flag: got %h expected 0", readdata); end
        reset = 1'b1;
        step();
        n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL post_reset_an: got %h expected fe", an); end
    endtask

    task automatic test_led();
        memwrite = 1'b1; dataadr = 32'h80; writedata = 32'hABCD1234; #1;
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL led_dmem_we: got %b expected 0", dmem_we); end
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL led_before_edge: got %h expected 0000", led); end
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL led_write: got %h expected 1234", led); end
        n_checks++; if (readdata !== 32'h00001234) begin n_fail++; $display("FAIL led_read: got %h expected 00001234", readdata); end
    endtask

    task automatic test_dmem_and_unmapped();
        memwrite = 1'b1; dataadr = 32'h54; writedata = 32'h0; #1;
        n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL dmem_we: got %b expected 1", dmem_we); end
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL led_kept_dmem: got %h expected 1234", led); end
        memwrite = 1'b1; dataadr = 32'hA0; writedata = 32'hFFFFFFFF; #1;
        n_checks++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL unmapped_dmem_we: got %b expected 0", dmem_we); end
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", readdata); end
        n_checks++; if (led !== 16'h1234) begin n_fail++; $display("FAIL led_kept_unmapped: got %h expected 1234", led); end
        // 0x88 is read-only: a store must not disturb later state
        memwrite = 1'b1; dataadr = 32'h88; writedata = 32'hFFFFFFFF;
        step();
        memwrite = 1'b0;
    endtask

    task automatic test_switch();
        dataadr = 32'h88; switches = 16'h5A5A; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL sw_lat0: got %h expected 0", readdata); end
        step();
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL sw_lat1: got %h expected 0", readdata); end
        step();
        n_checks++; if (readdata !== 32'h00005A5A) begin n_fail++; $display("FAIL sw_lat2: got %h expected 00005a5a", readdata); end
    endtask

    task automatic test_button();
        dataadr = 32'h8C; btn = 1'b1;
        step();
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL btn_lat1: got %h expected 0", readdata); end
        step();
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL btn_lat2: got %h expected 0", readdata); end
        step();
        n_checks++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL btn_lat3: got %h expected 1", readdata); end
        btn = 1'b0;
        step(); step(); step();
        n_checks++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL btn_sticky: got %h expected 1", readdata); end
        memwrite = 1'b1; writedata = 32'hDEADBEEF;
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (readdata !== 32'h0) begin n_fail++; $display("FAIL btn_clear: got %h expected 0", readdata); end
        // rise detected after the 2nd edge, so the clear on the 3rd edge collides with it
        btn = 1'b1;
        step(); step();
        memwrite = 1'b1;
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (readdata !== 32'h1) begin n_fail++; $display("FAIL btn_set_wins: got %h expected 1", readdata); end
        btn = 1'b0;
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [8];
        logic [7:0] exp_an;
        int         d;
`ifdef MMIO_BLANK_LEADING_ZERO_EN
        exp_seg = '{7'h00, 7'h40, 7'h0E, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        exp_seg = '{7'h00, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
        reset = 1'b0; memwrite = 1'b0;
        step();
        reset = 1'b1; memwrite = 1'b1; dataadr = 32'h84; writedata = 32'h00000F08;
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (readdata !== 32'h00000F08) begin n_fail++; $display("FAIL segdata_read: got %h expected 00000f08", readdata); end
        // after k edges from release the counter holds k, digit = k/2
        for (int k = 1; k <= 18; k++) begin
            d = (k / 2) % 8;
            exp_an = ~(8'b1 << d);
            n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL scan_an k=%0d: got %h expected %h", k, an, exp_an); end
            n_checks++; if (seg !== exp_seg[d]) begin n_fail++; $display("FAIL scan_seg k=%0d: got %h expected %h", k, seg, exp_seg[d]); end
            step();
        end
        // mid-scan reset with a coincident LED store
        memwrite = 1'b1; dataadr = 32'h80; writedata = 32'h00005555;
        step(); step();
        reset = 1'b0; #1;
        n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL midscan_reset_an: got %h expected fe", an); end
        step();
        memwrite = 1'b0; #1;
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_drops_write: got %h expected 0000", led); end
        n_checks++; if (seg !== 7'h40) begin n_fail++; $display("FAIL midscan_reset_seg: got %h expected 40", seg); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_led();
        test_dmem_and_unmapped();
        test_switch();
        test_button();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
